// File: rtl/fp_conv_pipe_pkg.sv
// Shared types and helpers for the pipelined floating-point format converter.
// Also defines the FP_IEEE754_T struct macro used to unpack {sign, exp, mant}.
`ifndef FP_IEEE754_T
`define FP_IEEE754_T(X, M) struct packed {logic sign; logic [(X)-1:0] exp; logic [(M)-1:0] mant;}
`endif

package fp_conv_pipe_pkg;

    typedef enum logic [1:0] {
        FPC_NORM,
        FPC_ZERO,
        FPC_INF,
        FPC_NAN
    } fp_class_t;

    // IEEE754 exponent bias for an n-bit exponent field.
    function automatic int EXP_OFFSET(input int n);
        return (1 << (n - 1)) - 1;
    endfunction

    function automatic int MAX(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Signed width that holds any rebiased exponent plus a rounding carry.
    function automatic int CONV_EXW(input int inx, input int onx);
        return MAX(inx, onx) + 2;
    endfunction

endpackage

// File: rtl/fp_conv_pipe_if.sv
// Handshake bus for fp_conv_pipe: input valid/ready/data and output valid/ready/data/flags.
interface fp_conv_pipe_if #(
    parameter int unsigned INX = 8,
    parameter int unsigned INM = 23,
    parameter int unsigned ONX = 5,
    parameter int unsigned ONM = 10
) ();
    logic               IN_VALID;
    logic               IN_READY;
    logic [INX+INM:0]   A;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic [ONX+ONM:0]   XOUT;
    logic               OVF;
    logic               UNF;

    // Converter side.
    modport slave (
        input  IN_VALID, A, OUT_READY,
        output IN_READY, OUT_VALID, XOUT, OVF, UNF
    );

    // Producer/consumer side.
    modport master (
        output IN_VALID, A, OUT_READY,
        input  IN_READY, OUT_VALID, XOUT, OVF, UNF
    );
endinterface

// File: rtl/fp_conv_pipe_round_pack.sv
// fp_round_pack: combinational rounding, range check and packing of one converted value.
// FP_CONV_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fp_round_pack
    import fp_conv_pipe_pkg::*;
#(
    parameter int unsigned ONX = 5,
    parameter int unsigned ONM = 10,
    parameter int unsigned EXW = 10
) (
    input  fp_class_t               i_class,
    input  logic                    i_sign,
    input  logic signed [EXW-1:0]   i_ex,
    input  logic [ONM-1:0]          i_mant,
    input  logic                    i_g,
    input  logic                    i_s,
    output logic [ONX+ONM:0]        o_x,
    output logic                    o_ovf,
    output logic                    o_unf
);
    localparam logic signed [EXW-1:0] EMAX = EXW'((1 << ONX) - 1);

    logic                   w_inc;
    logic [ONM:0]           w_mant_inc;
    logic [ONM-1:0]         w_mant_fin;
    logic signed [EXW-1:0]  w_ex_fin;

`ifdef FP_CONV_RNE_EN
    assign w_inc = i_g && (i_s || i_mant[0]);
`else
    logic w_unused;
    assign w_unused = i_g ^ i_s;
    assign w_inc    = 1'b0;
`endif

    // Round, then fold a mantissa carry-out into the exponent.
    always_comb begin
        w_mant_inc = {1'b0, i_mant} + {{ONM{1'b0}}, w_inc};
        w_mant_fin = w_mant_inc[ONM-1:0];
        w_ex_fin   = i_ex;
        if (w_mant_inc[ONM]) begin
            w_mant_fin = '0;
            w_ex_fin   = i_ex + $signed(EXW'(1));
        end
    end

    // Output class priority: NaN, Inf, zero, overflow, underflow, normal.
    always_comb begin
        o_x   = {i_sign, w_ex_fin[ONX-1:0], w_mant_fin};
        o_ovf = 1'b0;
        o_unf = 1'b0;
        unique case (i_class)
            FPC_NAN:  o_x = {1'b0, {ONX{1'b1}}, {{(ONM-1){1'b0}}, 1'b1}};
            FPC_INF:  o_x = {i_sign, {ONX{1'b1}}, {ONM{1'b0}}};
            FPC_ZERO: o_x = {i_sign, {(ONX+ONM){1'b0}}};
            default: begin
                if (w_ex_fin >= EMAX) begin
                    o_x   = {i_sign, {ONX{1'b1}}, {ONM{1'b0}}};
                    o_ovf = 1'b1;
                end else if (w_ex_fin[EXW-1] || (w_ex_fin == '0)) begin
                    o_x   = {i_sign, {(ONX+ONM){1'b0}}};
                    o_unf = 1'b1;
                end
            end
        endcase
    end
endmodule

// File: rtl/fp_conv_pipe.sv
// fp_conv_pipe: 2-stage valid/ready float format converter (default float32 -> float16).
// Stage 1 classifies/rebiases/splits the mantissa, stage 2 registers the rounded result.
// Build option FP_CONV_RNE_EN enables round-to-nearest-even (else truncation).
module fp_conv_pipe
    import fp_conv_pipe_pkg::*;
#(
    parameter int unsigned INX = 8,
    parameter int unsigned INM = 23,
    parameter int unsigned ONX = 5,
    parameter int unsigned ONM = 10
) (
    input  logic          CLK,
    input  logic          RST,
    fp_conv_pipe_if.slave bus
);
    localparam int unsigned   EXW   = int'(CONV_EXW(INX, ONX));
    localparam int unsigned   GB    = INM - ONM - 1;
    localparam logic [INM-1:0] SMASK = (INM'(1) << GB) - INM'(1);

    typedef `FP_IEEE754_T(INX, INM) fp_in_t;

    fp_in_t                 w_a;
    fp_class_t              w_class;
    logic signed [EXW-1:0]  w_ex;
    logic                   w_s2_ready;
    logic                   w_in_ready;
    logic                   w_in_fire;
    logic [ONX+ONM:0]       w_x;
    logic                   w_ovf;
    logic                   w_unf;

    logic                   r_s1_valid;
    fp_class_t              r_s1_class;
    logic                   r_s1_sign;
    logic signed [EXW-1:0]  r_s1_ex;
    logic [ONM-1:0]         r_s1_mant;
    logic                   r_s1_g;
    logic                   r_s1_s;
    logic                   r_out_valid;
    logic [ONX+ONM:0]       r_xout;
    logic                   r_ovf;
    logic                   r_unf;

    assign w_a        = bus.A;
    assign w_s2_ready = !r_out_valid || bus.OUT_READY;
    assign w_in_ready = !r_s1_valid || w_s2_ready;
    assign w_in_fire  = bus.IN_VALID && w_in_ready;

    assign w_ex = $signed({{(EXW-INX){1'b0}}, w_a.exp}) - $signed(EXW'(EXP_OFFSET(INX)))
                + $signed(EXW'(EXP_OFFSET(ONX)));

    // Classify the input; denormal inputs are flushed to zero.
    always_comb begin
        w_class = FPC_NORM;
        if (w_a.exp == {INX{1'b1}}) begin
            w_class = (w_a.mant != '0) ? FPC_NAN : FPC_INF;
        end else if (w_a.exp == '0) begin
            w_class = FPC_ZERO;
        end
    end

    // Stage 1: load on input transfer, empty when content moves on with nothing behind it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s1_class <= FPC_NORM;
            r_s1_sign  <= 1'b0;
            r_s1_ex    <= '0;
            r_s1_mant  <= '0;
            r_s1_g     <= 1'b0;
            r_s1_s     <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_class <= w_class;
            r_s1_sign  <= w_a.sign;
            r_s1_ex    <= w_ex;
            r_s1_mant  <= w_a.mant[INM-1 -: ONM];
            r_s1_g     <= w_a.mant[GB];
            r_s1_s     <= |(w_a.mant & SMASK);
        end else if (w_s2_ready) begin
            r_s1_valid <= 1'b0;
        end
    end

    fp_round_pack #(
        .ONX (ONX),
        .ONM (ONM),
        .EXW (EXW)
    ) u_round_pack (
        .i_class (r_s1_class),
        .i_sign  (r_s1_sign),
        .i_ex    (r_s1_ex),
        .i_mant  (r_s1_mant),
        .i_g     (r_s1_g),
        .i_s     (r_s1_s),
        .o_x     (w_x),
        .o_ovf   (w_ovf),
        .o_unf   (w_unf)
    );

    // Stage 2: advance whenever the output slot is free or being consumed; hold otherwise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_xout      <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_xout <= w_x;
                r_ovf  <= w_ovf;
                r_unf  <= w_unf;
            end
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_VALID = r_out_valid;
    assign bus.XOUT      = r_xout;
    assign bus.OVF       = r_ovf;
    assign bus.UNF       = r_unf;
endmodule

// File: tb/tb_fp_conv_pipe.sv
// Testbench for fp_conv_pipe: directed vectors, a float32->float16 reference model and a
// scoreboard compared on every negedge where OUT_VALID is high.
module tb_fp_conv_pipe;
    logic CLK;
    logic RST;
    int   errors = 0;
    int   checks = 0;
    logic [17:0] sb[$];

    fp_conv_pipe_if bus ();

    fp_conv_pipe dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: float32 bits -> {half bits, ovf, unf} using significand arithmetic.
    function automatic logic [17:0] model(input logic [31:0] a);
        logic        sg;
        int          e, q, rem, oe;
        logic [15:0] h;
        sg = a[31];
        e  = int'(a[30:23]);
        if (e == 255) begin
            if (a[22:0] != 0) return {16'h7C01, 2'b00};
            return {sg, 15'h7C00, 2'b00};
        end
        if (e == 0) return {sg, 15'h0000, 2'b00};
        q   = int'({1'b1, a[22:0]}) / 8192;
        rem = int'({1'b1, a[22:0]}) % 8192;
`ifdef FP_CONV_RNE_EN
        if (rem > 4096 || (rem == 4096 && (q % 2) == 1)) q = q + 1;
`endif
        oe = e - 127 + 15;
        if (q == 2048) begin
            q  = 1024;
            oe = oe + 1;
        end
        if (oe >= 31) return {sg, 15'h7C00, 2'b10};
        if (oe <= 0) return {sg, 15'h0000, 2'b01};
        h = {sg, oe[4:0], q[9:0]};
        return {h, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one sample and wait (bounded) for it to be accepted.
    task automatic send(input logic [31:0] a);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.A        = a;
        while (!ok && n < 100) begin
            @(negedge CLK);
            ok = bus.IN_READY;
            @(posedge CLK);
            #1;
            n++;
        end
        bus.IN_VALID = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge CLK);
            n++;
        end
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard: every valid output must equal the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.OUT_VALID) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", {14'd0, bus.XOUT, bus.OVF, bus.UNF}, 32'h3FFFF);
                end else begin
                    chk("sb_out", {14'd0, bus.XOUT, bus.OVF, bus.UNF}, {14'd0, sb[0]});
                    if (bus.OUT_READY) void'(sb.pop_front());
                end
            end
            if (bus.IN_VALID && bus.IN_READY) sb.push_back(model(bus.A));
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [15:0] x;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{32'h3F800000, 16'h3C00, 1'b0, 1'b0};
        vecs[1]  = '{32'h40C00000, 16'h4600, 1'b0, 1'b0};
        vecs[2]  = '{32'h40C7AE14, 16'h463D, 1'b0, 1'b0};
`ifdef FP_CONV_RNE_EN
        vecs[3]  = '{32'h3F801000, 16'h3C00, 1'b0, 1'b0};
        vecs[4]  = '{32'h3F803000, 16'h3C02, 1'b0, 1'b0};
        vecs[5]  = '{32'h3F7FF000, 16'h3C00, 1'b0, 1'b0};
`else
        vecs[3]  = '{32'h3F801000, 16'h3C00, 1'b0, 1'b0};
        vecs[4]  = '{32'h3F803000, 16'h3C01, 1'b0, 1'b0};
        vecs[5]  = '{32'h3F7FF000, 16'h3BFF, 1'b0, 1'b0};
`endif
        vecs[6]  = '{32'h7FC00000, 16'h7C01, 1'b0, 1'b0};
        vecs[7]  = '{32'hFF800000, 16'hFC00, 1'b0, 1'b0};
        vecs[8]  = '{32'h80000000, 16'h8000, 1'b0, 1'b0};
        vecs[9]  = '{32'h47800000, 16'h7C00, 1'b1, 1'b0};
        vecs[10] = '{32'h33800000, 16'h0000, 1'b0, 1'b1};
        vecs[11] = '{32'h40000000, 16'h4000, 1'b0, 1'b0};
        vecs[12] = '{32'hC0C00000, 16'hC600, 1'b0, 1'b0};
        vecs[13] = '{32'h477FE000, 16'h7BFF, 1'b0, 1'b0};

        RST           = 1'b1;
        bus.IN_VALID  = 1'b0;
        bus.A         = '0;
        bus.OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        chk("rst_xout", {16'd0, bus.XOUT}, 32'd0);
        chk("rst_ovf", {31'd0, bus.OVF}, 32'd0);
        chk("rst_unf", {31'd0, bus.UNF}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.IN_READY}, 32'd1);

        // Pin the model against hand-computed values.
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("model_%0d", i), {14'd0, model(vecs[i].a)},
                {14'd0, vecs[i].x, vecs[i].ovf, vecs[i].unf});
        end

        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Latency: OUT_VALID exactly two cycles after transfer.
        send(vecs[0].a);
        chk("lat_early", {31'd0, bus.OUT_VALID}, 32'd0);
        @(posedge CLK);
        #1;
        chk("lat_valid", {31'd0, bus.OUT_VALID}, 32'd1);
        chk("lat_xout", {16'd0, bus.XOUT}, 32'h3C00);
        drain();

        // Continuous flow of every vector.
        for (int i = 1; i < 14; i++) send(vecs[i].a);
        drain();

        // Backpressure: two accepted, third stalls, output held.
        bus.OUT_READY = 1'b0;
        send(32'h3F800000);
        send(32'h40C00000);
        bus.IN_VALID = 1'b1;
        bus.A        = 32'h40000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_in_ready", {31'd0, bus.IN_READY}, 32'd0);
            chk("bp_hold_xout", {16'd0, bus.XOUT}, 32'h3C00);
            chk("bp_hold_valid", {31'd0, bus.OUT_VALID}, 32'd1);
        end
        @(posedge CLK);
        #1;
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        chk("rel_x0", {16'd0, bus.XOUT}, 32'h3C00);
        chk("rel_in_ready", {31'd0, bus.IN_READY}, 32'd1);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        @(negedge CLK);
        chk("rel_x1", {16'd0, bus.XOUT}, 32'h4600);
        @(negedge CLK);
        chk("rel_x2", {16'd0, bus.XOUT}, 32'h4000);
        chk("rel_x2_valid", {31'd0, bus.OUT_VALID}, 32'd1);
        drain();

        // Reset with both stages full.
        bus.OUT_READY = 1'b0;
        send(32'h47800000);
        send(32'h40C00000);
        #1;
        RST = 1'b1;
        #1;
        chk("mrst_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        chk("mrst_xout", {16'd0, bus.XOUT}, 32'd0);
        chk("mrst_ovf", {31'd0, bus.OVF}, 32'd0);
        chk("mrst_unf", {31'd0, bus.UNF}, 32'd0);
        chk("mrst_in_ready", {31'd0, bus.IN_READY}, 32'd1);
        sb.delete();
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        send(32'h40C7AE14);
        chk("post_rst_early", {31'd0, bus.OUT_VALID}, 32'd0);
        @(posedge CLK);
        #1;
        chk("post_rst_valid", {31'd0, bus.OUT_VALID}, 32'd1);
        chk("post_rst_xout", {16'd0, bus.XOUT}, 32'h463D);
        drain();
        repeat (3) @(posedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_conv_pipe.md
Name: fp_conv_pipe

Overview:
- Pipelined, handshaked floating-point format converter (default float32 -> float16).
- Sits directly downstream of the combinational FPU datapath: takes FPU results and produces narrow outputs on the output bus.
- Unlike the combinational converter, it rounds correctly and handles special values, overflow and underflow.
- 2-stage pipeline, valid/ready on both sides, throughput 1 sample per cycle.

Parameters:
- INX, 8, input exponent width
- INM, 23, input mantissa width
- ONX, 5, output exponent width
- ONM, 10, output mantissa width (must be < INM)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- IN_VALID  in  1  input sample valid
- IN_READY  out  1  converter can accept an input this cycle
- A  in  INX+INM+1  input value, IEEE754 layout {sign, exp, mant}
- OUT_VALID  out  1  XOUT/flags valid
- OUT_READY  in  1  consumer accepts XOUT this cycle
- XOUT  out  ONX+ONM+1  converted value
- OVF  out  1  overflow to infinity occurred for this XOUT
- UNF  out  1  underflow to zero occurred for this XOUT

Behaviour:
- Reset: async assert clears s1_valid, OUT_VALID, XOUT, OVF and UNF to 0. Reset mid-operation drops in-flight samples.
- Handshake:
  - Transfer on IN_VALID&&IN_READY or OUT_VALID&&OUT_READY.
  - s2_ready = !OUT_VALID || OUT_READY.
  - IN_READY = !s1_valid || s2_ready (combinational path from OUT_READY is allowed).
  - XOUT and flags are held stable while OUT_VALID && !OUT_READY.
- Latency: exactly 2 cycles from input transfer to OUT_VALID when there is no backpressure. Order is preserved, with no bubbles under continuous flow.
- Stage 1 (registered on input transfer):
  - Classify: exp all-ones with mant!=0 -> NaN; exp all-ones with mant==0 -> Inf; exp==0 -> zero (input denormals flushed).
  - Rebias: ex = exp - EXP_OFFSET(INX) + EXP_OFFSET(ONX), computed signed with width max(INX,ONX)+2.
  - Keep the top ONM mantissa bits.
  - G = mant bit INM-ONM-1; S = OR of mant bits below G.
- Stage 2 (registered when s2_ready):
  - Round-to-nearest-even: increment if G && (S || lsb).
  - Mantissa carry-out: mantissa becomes 0, ex+1.
  - Output class priority:
    - NaN -> canonical {0, all-ones, 0..01}.
    - Inf -> {sign, all-ones, 0}.
    - Zero -> {sign, 0, 0}.
    - Final ex >= 2^ONX-1 -> {sign, all-ones, 0}, OVF=1.
    - ex <= 0 -> {sign, 0, 0}, UNF=1 (no output denormals).
    - Otherwise pack {sign, ex[ONX-1:0], mant}.
  - OVF and UNF are 0 for every other case.
- Simultaneous events: a stage may load and unload in the same cycle. The stage-1 register is overwritten only when its content moves to stage 2 in that cycle.

Optional Feature:
- FP_CONV_RNE_EN defined: round-to-nearest-even as above.
- FP_CONV_RNE_EN undefined:
  - Truncation: G and S are ignored, so there is no carry.
  - Overflow and underflow are detected on the rebiased exponent only.

Decomposition:
- Package fp gains the following (EXP_OFFSET reused):
  - CONV_EXW(INX,ONX) = MAX(INX,ONX)+2.
  - enum fp_class_t {FPC_NORM, FPC_ZERO, FPC_INF, FPC_NAN}.
- IEEE754 struct macro reused for unpacking.
- One sub-module, fp_round_pack: combinational stage-2 logic. Inputs are class, sign, ex, mant, G, S; outputs are the packed value, OVF and UNF. It is instantiated once and registered in fp_conv_pipe.

Test Plan:
- Normal values, OUT_READY=1 (all arrive 2 cycles after input): 0x3F800000 -> 0x3C00; 0x40C00000 -> 0x4600; 0x40C7AE14 -> 0x463D; OVF=UNF=0.
- Rounding (RNE): 0x3F801000 (tie, even) -> 0x3C00; 0x3F803000 -> 0x3C02; 0x3F7FF000 (carry) -> 0x3C00. Without FP_CONV_RNE_EN: 0x3C00, 0x3C01, 0x3BFF respectively.
- Specials: 0x7FC00000 -> 0x7C01; 0xFF800000 -> 0xFC00; 0x80000000 -> 0x8000. Flags 0 in all three cases.
- Range limits: 0x47800000 -> 0x7C00 with OVF=1; 0x33800000 -> 0x0000 with UNF=1.
- Backpressure: OUT_READY=0, inputs 1.0, 6.0, 2.0 back-to-back.
  - First two accepted; IN_READY falls; XOUT is held at 0x3C00.
  - Release OUT_READY: outputs 0x3C00, 0x4600, 0x4000 on consecutive cycles.
- Reset mid-stream: assert RST with both stages full. OUT_VALID, XOUT and flags clear immediately (asynchronously). After release, the next input appears after 2 cycles and no stale data is output.
